// File: rtl/sequential_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and
// the width of the iteration counter.
package sequential_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold WIDTH-1; keep at least one bit for degenerate widths.
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sequential_divider_datapath.sv
// Restoring-divider datapath: Q/R/D/dbz registers, trial subtractor and
// restore mux. Driven purely by load/step strobes, unaware of FSM state.
module sequential_divider_datapath #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_dbz
);

  // The partial remainder's top bit is provably zero after every step,
  // so only WIDTH bits of R are stored.
  logic [WIDTH-1:0] r_q, r_r, r_d;
  logic             r_dbz;
  logic [WIDTH:0]   w_s, w_t;

  assign w_s = {r_r, r_q[WIDTH-1]};
  assign w_t = w_s - {1'b0, r_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_r   <= '0;
      r_d   <= '0;
      r_dbz <= 1'b0;
    end else if (i_load) begin
      r_q   <= i_dividend;
      r_r   <= '0;
      r_d   <= i_divisor;
      r_dbz <= (i_divisor == '0);
    end else if (i_step) begin
      // Borrow clear: keep the difference; otherwise restore the shifted value.
      if (!w_t[WIDTH]) begin
        r_r <= w_t[WIDTH-1:0];
        r_q <= {r_q[WIDTH-2:0], 1'b1};
      end else begin
        r_r <= w_s[WIDTH-1:0];
        r_q <= {r_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign o_quotient  = r_q;
  assign o_remainder = r_r;
  assign o_dbz       = r_dbz;

endmodule

// File: rtl/sequential_divider.sv
// Constant-time radix-2 restoring divider: control FSM with iteration
// counter, plus the datapath sub-module. WIDTH+1 cycles accept-to-done.
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output logic             quotientDone
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_load, w_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      IDLE: if (start) begin
        w_load      = 1'b1;
        w_cnt_nxt   = CNT_W'(WIDTH - 1);
        w_state_nxt = ITER;
      end
      ITER: begin
        w_step = 1'b1;
        if (r_cnt == '0) w_state_nxt = DONE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy         = (r_state != IDLE);
  assign quotientDone = (r_state == DONE);

  sequential_divider_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_dividend (dividend),
    .i_divisor  (divisor),
    .o_quotient (quotient),
    .o_remainder(remainder),
    .o_dbz      (div_by_zero)
  );

endmodule

// File: tb/tb_sequential_divider.sv
// Directed + exhaustive bench for sequential_divider (WIDTH=4) with a
// result scoreboard and exact-latency checks on every operation.
module tb_sequential_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] quotient, remainder;
  logic         div_by_zero, busy, quotientDone;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } res_t;

  res_t sb[$];
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  sequential_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .quotientDone(quotientDone)
  );

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t m;
    if (b == 0) begin
      m.q = '1;
      m.r = a;
    end else begin
      m.q = a / b;
      m.r = a % b;
    end
    m.z = (b == 0);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive operands before an edge; that edge is the accepting edge 0.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Check cycles 1..5 after accept: busy throughout, done only in cycle 5,
  // results match the scoreboard; cycle 6 must be back in IDLE.
  task automatic finish_op(input string tag, input bit scramble);
    res_t e;
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      chk({tag, "_done"}, 16'(quotientDone), 16'(c == W + 1));
      chk({tag, "_busy"}, 16'(busy), 16'd1);
      if (c == W + 1) begin
        if (sb.size() == 0) begin
          chk({tag, "_sb_empty"}, 16'd0, 16'd1);
        end else begin
          e = sb.pop_front();
          chk({tag, "_res"}, 16'({quotient, remainder, div_by_zero}), 16'(e));
        end
      end
      if (scramble) begin
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
    end
    @(negedge clk);
    chk({tag, "_idle_done"}, 16'(quotientDone), 16'd0);
    chk({tag, "_idle_busy"}, 16'(busy), 16'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out", 16'({quotient, remainder, div_by_zero, busy, quotientDone}), 16'd0);

    accept(4'd13, 4'd3, 1'b0); finish_op("d13_3", 1'b0);
    accept(4'd7,  4'd0, 1'b0); finish_op("d7_0",  1'b0);
    accept(4'd15, 4'd1, 1'b0); finish_op("d15_1", 1'b0);
    accept(4'd2,  4'd9, 1'b0); finish_op("d2_9",  1'b0);
    accept(4'd0,  4'd5, 1'b0); finish_op("d0_5",  1'b0);

    // start held high with operands changing: first result only, next
    // accept lands on edge 6 with the operands present then.
    accept(4'd11, 4'd2, 1'b1);
    finish_op("hold_a", 1'b1);
    dividend = 4'd9;
    divisor  = 4'd4;
    sb.push_back(model(4'd9, 4'd4));
    @(posedge clk);
    #1 start = 1'b0;
    finish_op("hold_b", 1'b0);

    // Reset mid-operation discards the result.
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_out", 16'({quotient, remainder, div_by_zero, busy, quotientDone}), 16'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_quiet", 16'({busy, quotientDone}), 16'd0);
    end
    accept(4'd13, 4'd3, 1'b0); finish_op("post_rst", 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        accept(W'(a), W'(b), 1'b0);
        finish_op("exh", 1'b0);
      end
    end

    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
